alu_cmd_issuer: RTL and testbench



---
 rtl/alu_cmd_issuer.sv | 197 +++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Command-side initiator for a combinational 32-bit ALU. The block accepts
//   one operation at a time over a valid/ready request interface and drives
//   the ALU for one pass per cycle. It registers the ALU result and flags and
//   returns them over a valid/ready response interface. A 64-bit add/sub runs
//   as two chained passes: the low half first, then the high half, with the
//   low-half carry fed into the second pass.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_op, req_wide,     opcode, 64-bit select, carry-in,
//   req_cin, req_a/req_b  and 64-bit operands (narrow ops use [WIDTH-1:0])
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              result; narrow results are zero-extended
//   rsp_z/v/c/n           result flags
//   rsp_err               the request was illegal (data and flags are 0)
//   alu_a/b/cntrl/cin     registered drive to the ALU (0 when the ALU is idle)
//   alu_out, alu_zero/ovf/carry/neg   combinational ALU result and flags
module alu_cmd_issuer #(
  parameter int WIDTH = 32,
  parameter int CNTRL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CNTRL-1:0]     req_op,
  input  logic                 req_wide,
  input  logic                 req_cin,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_z,
  output logic                 rsp_v,
  output logic                 rsp_c,
  output logic                 rsp_n,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [CNTRL-1:0]     alu_cntrl,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_ovf,
  input  logic                 alu_carry,
  input  logic                 alu_neg
);

  localparam logic [CNTRL-1:0] OP_ADD  = CNTRL'(5);
  localparam logic [CNTRL-1:0] OP_ADDU = CNTRL'(6);
  localparam logic [CNTRL-1:0] OP_SUB  = CNTRL'(7);
  localparam logic [CNTRL-1:0] OP_LAST = CNTRL'(13);  // AND, highest legal opcode

  typedef enum logic [1:0] {
    IDLE,
    EXEC_LO,
    EXEC_HI,
    RESP
  } state_t;

  state_t               state;
  logic [CNTRL-1:0]     op_q;
  logic                 wide_q;
  logic [WIDTH-1:0]     a_hi_q;
  logic [WIDTH-1:0]     b_hi_q;
  logic                 c_lo;
  logic                 req_illegal;

  function automatic logic is_addsub(input logic [CNTRL-1:0] op);
    return (op == OP_ADD) || (op == OP_ADDU) || (op == OP_SUB);
  endfunction

  // Only the add opcodes consume a carry-in; every other op gets 0.
  function automatic logic takes_cin(input logic [CNTRL-1:0] op);
    return (op == OP_ADD) || (op == OP_ADDU);
  endfunction

  assign req_illegal = (req_op > OP_LAST) || (req_wide && !is_addsub(req_op));

  // NOTE: every state register below is written with non-blocking assignments,
  // so each branch sees the values from before the edge (e.g. EXEC_LO can copy
  // alu_carry into both c_lo and alu_cin in the same cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      op_q      <= '0;
      wide_q    <= 1'b0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      c_lo      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_z     <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cntrl <= '0;
      alu_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            wide_q    <= req_wide;
            a_hi_q    <= req_a[2*WIDTH-1:WIDTH];
            b_hi_q    <= req_b[2*WIDTH-1:WIDTH];
            // Start every response from a clean slate; the error path keeps it.
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_c     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_err   <= req_illegal;
            if (req_illegal) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // Operands are registered here so the ALU sees them for the
              // whole EXEC_LO cycle.
              alu_a     <= req_a[WIDTH-1:0];
              alu_b     <= req_b[WIDTH-1:0];
              alu_cntrl <= req_op;
              alu_cin   <= takes_cin(req_op) & req_cin;
              state     <= EXEC_LO;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        EXEC_LO: begin
          rsp_data <= {{WIDTH{1'b0}}, alu_out};
          c_lo     <= alu_carry;
          if (wide_q) begin
            alu_a   <= a_hi_q;
            alu_cin <= alu_carry;
            // High half of a subtract is a + ~b + borrow-chain carry. The
            // ALU's SUB would add its own +1, so use ADDU on ~b instead.
            if (op_q == OP_SUB) begin
              alu_b     <= ~b_hi_q;
              alu_cntrl <= OP_ADDU;
            end else begin
              alu_b     <= b_hi_q;
              alu_cntrl <= op_q;
            end
            state <= EXEC_HI;
          end else begin
            rsp_z     <= alu_zero;
            rsp_v     <= alu_ovf;
            rsp_c     <= alu_carry;
            rsp_n     <= alu_neg;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cntrl <= '0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        EXEC_HI: begin
          rsp_data[2*WIDTH-1:WIDTH] <= alu_out;
          // The ALU zero flag only covers the high half, so it is not reported.
          rsp_z     <= 1'b0;
          rsp_v     <= alu_ovf;
          rsp_c     <= alu_carry;
          rsp_n     <= alu_neg;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_cntrl <= '0;
          alu_cin   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
//   Directed bench for alu_cmd_issuer. A small behavioural model of the
//   32-bit ALU closes the loop on the alu_* ports; every response is compared
//   against hand-computed constants.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic        req_cin;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_z, rsp_v, rsp_c, rsp_n, rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_cntrl;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        alu_zero, alu_ovf, alu_carry, alu_neg;

  int n_tests = 0;
  int n_fail  = 0;

  // ALU drive seen after each edge of the last operation (index = edges
  // since the accepting edge).
  logic [31:0] log_a     [10];
  logic [31:0] log_b     [10];
  logic [3:0]  log_cntrl [10];
  logic        log_cin   [10];
  logic        alu_touched;

  alu_cmd_issuer #(.WIDTH(32), .CNTRL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_wide  (req_wide),
    .req_cin   (req_cin),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_z     (rsp_z),
    .rsp_v     (rsp_v),
    .rsp_c     (rsp_c),
    .rsp_n     (rsp_n),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cntrl (alu_cntrl),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .alu_carry (alu_carry),
    .alu_neg   (alu_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: compares report their result on zero, arithmetic and
  // logic ops report Z/N from the result, adds/subs also report C and V.
  logic [32:0] sum;
  always_comb begin
    alu_out   = '0;
    alu_zero  = 1'b0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    alu_neg   = 1'b0;
    sum       = '0;
    case (alu_cntrl)
      4'd0: alu_zero = (alu_a == alu_b);
      4'd1: alu_zero = ($signed(alu_a) < $signed(alu_b));
      4'd2: alu_zero = (alu_a < alu_b);
      4'd3: alu_zero = ($signed(alu_a) > $signed(alu_b));
      4'd4: alu_zero = (alu_a > alu_b);
      4'd5, 4'd6: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_out   = sum[31:0];
        alu_carry = sum[32];
        if (alu_cntrl == 4'd5)
          alu_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd7: begin
        sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out   = sum[31:0];
        alu_carry = sum[32];
        alu_ovf   = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd8:  alu_out = alu_a << alu_b[4:0];
      4'd9:  alu_out = alu_a >> alu_b[4:0];
      4'd10: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd11: alu_out = alu_a | alu_b;
      4'd12: alu_out = alu_a ^ alu_b;
      4'd13: alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
    if (alu_cntrl >= 4'd5) begin
      alu_zero = (alu_out == 32'd0);
      alu_neg  = alu_out[31];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {z, v, c, n, err}.
  task automatic check_rsp(input string tag, input logic [63:0] exp_data, input logic [4:0] exp_flags);
    check({tag, ".data"},  rsp_data, exp_data);
    check({tag, ".flags"}, {59'd0, rsp_z, rsp_v, rsp_c, rsp_n, rsp_err}, {59'd0, exp_flags});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req_ready"}, {63'd0, req_ready}, 64'd0);
    check({tag, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check_rsp(tag, 64'd0, 5'b00000);
    check({tag, ".alu"}, {alu_a, alu_b}, 64'd0);
    check({tag, ".alu_ctl"}, {59'd0, alu_cntrl, alu_cin}, 64'd0);
  endtask

  // Presents one request starting just after an edge, then counts edges
  // (the accepting edge is 1) until rsp_valid appears.
  task automatic issue(input logic [3:0] op, input logic wide, input logic cin,
                       input logic [63:0] a, input logic [63:0] b, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_wide  = wide;
    req_cin   = cin;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_valid   = 1'b0;
    lat         = 1;
    alu_touched = 1'b0;
    while (!rsp_valid && lat < 9) begin
      log_a[lat]     = alu_a;
      log_b[lat]     = alu_b;
      log_cntrl[lat] = alu_cntrl;
      log_cin[lat]   = alu_cin;
      if (alu_a != 0 || alu_cntrl != 0) alu_touched = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, ".ready_back"}, {63'd0, req_ready}, 64'd1);
  endtask

  int lat;
  logic [63:0] held_data;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_wide  = 1'b0;
    req_cin   = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Narrow ADD, cin = 0 and cin = 1.
    issue(4'd5, 1'b0, 1'b0, 64'h0a0a0a0a, 64'h0a0a0a0a, lat);
    check("add.latency", 64'(lat), 64'd2);
    check("add.alu_cntrl", {60'd0, log_cntrl[1]}, 64'd5);
    check("add.alu_cin", {63'd0, log_cin[1]}, 64'd0);
    check_rsp("add", 64'h14141414, 5'b00000);
    take_rsp("add");

    issue(4'd5, 1'b0, 1'b1, 64'h0a0a0a0a, 64'h0a0a0a0a, lat);
    check("addc.alu_cin", {63'd0, log_cin[1]}, 64'd1);
    check_rsp("addc", 64'h14141415, 5'b00000);
    take_rsp("addc");

    // Wide ADD: carry out of the low half feeds the high pass.
    issue(4'd5, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 64'd1, lat);
    check("wadd.latency", 64'(lat), 64'd3);
    check("wadd.hi_cin", {63'd0, log_cin[2]}, 64'd1);
    check("wadd.hi_cntrl", {60'd0, log_cntrl[2]}, 64'd5);
    check_rsp("wadd", 64'h00000001_00000000, 5'b00000);
    take_rsp("wadd");

    // Wide SUB 0 - 1 (cin is ignored for SUB).
    issue(4'd7, 1'b1, 1'b1, 64'd0, 64'd1, lat);
    check("wsub.latency", 64'(lat), 64'd3);
    check("wsub.lo_cin", {63'd0, log_cin[1]}, 64'd0);
    check("wsub.lo_cntrl", {60'd0, log_cntrl[1]}, 64'd7);
    check("wsub.hi_cntrl", {60'd0, log_cntrl[2]}, 64'd6);
    check("wsub.hi_b", {32'd0, log_b[2]}, 64'hFFFFFFFF);
    check_rsp("wsub", 64'hFFFFFFFF_FFFFFFFF, 5'b00010);
    take_rsp("wsub");

    // Signed vs unsigned compare on the same operands.
    issue(4'd1, 1'b0, 1'b0, 64'hFFFFFFFF, 64'd1, lat);
    check_rsp("lt", 64'd0, 5'b10000);
    take_rsp("lt");
    issue(4'd2, 1'b0, 1'b0, 64'hFFFFFFFF, 64'd1, lat);
    check_rsp("ltu", 64'd0, 5'b00000);
    take_rsp("ltu");

    // Illegal requests never touch the ALU.
    issue(4'd14, 1'b0, 1'b0, 64'h12345678, 64'h1, lat);
    check("ill14.latency", 64'(lat), 64'd1);
    check("ill14.alu_idle", {59'd0, alu_cntrl, alu_touched}, 64'd0);
    check("ill14.alu_a", {32'd0, alu_a}, 64'd0);
    check_rsp("ill14", 64'd0, 5'b00001);
    take_rsp("ill14");

    issue(4'd11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
    check("illw.latency", 64'(lat), 64'd1);
    check("illw.alu_idle", {59'd0, alu_cntrl, alu_touched}, 64'd0);
    check_rsp("illw", 64'd0, 5'b00001);
    take_rsp("illw");

    // SRA under backpressure: the response must not move.
    issue(4'd10, 1'b0, 1'b0, 64'h80000000, 64'd4, lat);
    check("sra.latency", 64'(lat), 64'd2);
    check_rsp("sra", 64'hF8000000, 5'b00010);
    held_data = rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.valid", {63'd0, rsp_valid}, 64'd1);
      check("bp.req_ready", {63'd0, req_ready}, 64'd0);
      check("bp.data", rsp_data, held_data);
      check("bp.flags", {59'd0, rsp_z, rsp_v, rsp_c, rsp_n, rsp_err}, 64'b00010);
    end
    take_rsp("sra");

    // Reset during EXEC_HI of a wide ADD.
    req_valid = 1'b1;
    req_op    = 4'd5;
    req_wide  = 1'b1;
    req_cin   = 1'b0;
    req_a     = 64'h00000000_FFFFFFFF;
    req_b     = 64'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.in_hi", {59'd0, alu_cntrl, alu_cin}, {59'd0, 4'd5, 1'b1});
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid.no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    check("rst_mid.ready", {63'd0, req_ready}, 64'd1);
    rsp_ready = 1'b0;

    // Block is usable again after the aborted operation.
    issue(4'd12, 1'b0, 1'b0, 64'hF0F0F0F0, 64'hFFFF0000, lat);
    check_rsp("xor", 64'h0F0FF0F0, 5'b00000);
    take_rsp("xor");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
